// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the external async SRAM arbiter/sequencer.
//   state_e   : sequencer states (see sram_arbiter for the state table)
//   cnt_width : width of the strobe down-counter, sized for the longer of
//               the read and write strobe lengths
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RD_DONE  = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5
  } state_e;

  localparam logic PORT_P0 = 1'b0;
  localparam logic PORT_P1 = 1'b1;

  // $clog2(max(rd, we) + 1), never narrower than one bit.
  function automatic int cnt_width(input int unsigned rd_cycles,
                                   input int unsigned we_cycles);
    int unsigned longest;
    longest = (rd_cycles > we_cycles) ? rd_cycles : we_cycles;
    if (longest < 1) return 1;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin grant for the SRAM ports.
//   clk_i, reset_b_i : clock, async active-low reset
//   req_i[1:0]       : {port 1 request, port 0 request}
//   update_i         : the sequencer is accepting the grant this cycle
//   valid_o          : at least one port is requesting
//   grant_o          : index of the port that wins (0 or 1)
// last_grant resets to port 1 so port 0 wins the first contention.
module sram_rr_arb
  import sram_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_b_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       valid_o,
  output logic       grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    valid_o = |req_i;
    grant_o = PORT_P0;
    unique case (req_i)
      2'b01:   grant_o = PORT_P0;
      2'b10:   grant_o = PORT_P1;
      2'b11:   grant_o = ~last_grant_q;
      default: grant_o = PORT_P0;
    endcase
    last_grant_d = (update_i && valid_o) ? grant_o : last_grant_q;
  end

  always_ff @(posedge clk_i or negedge reset_b_i) begin
    if (!reset_b_i) begin
      last_grant_q <= PORT_P1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for a 256Kx16 asynchronous SRAM.
// Port 0 is the CPU path, port 1 a secondary master. Every ram_* output and
// every ack/rdata is a register, so nothing combinational reaches the pads.
//   clk_i, reset_b_i          : clock, async active-low reset
//   pN_req_i/we_i/addr_i/wdata_i : request, 1=write, word address, write data
//   pN_ack_o                  : one-cycle completion strobe
//   pN_rdata_o                : read data, valid while pN_ack_o=1, else 0
//   ram_cs_b_o/oe_b_o/we_b_o  : active-low SRAM strobes
//   ram_adr_o, ram_dout_o     : address and write data to the pads
//   ram_dout_en_o             : pad driver enable
//   ram_din_i                 : data from the pads
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | strobes high, bus released; grant and latch a request
// ST_RD        | cs/oe low for RD_CYCLES; ram_din captured on the last edge
// ST_RD_DONE   | cs/oe high, ack + rdata to the granted port
// ST_WR_SETUP  | cs low, address/data driven, we still high
// ST_WR_PULSE  | we low for WE_CYCLES
// ST_WR_HOLD   | we high, cs and data still driven, ack to the granted port
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_b_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              ram_cs_b_o,
  output logic              ram_oe_b_o,
  output logic              ram_we_b_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_dout_o,
  output logic              ram_dout_en_o,
  input  logic [DATA_W-1:0] ram_din_i
);

  localparam int CNT_W = cnt_width(RD_CYCLES, WE_CYCLES);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              cs_b_q, cs_b_d;
  logic              oe_b_q, oe_b_d;
  logic              we_b_q, we_b_d;
  logic              dout_en_q, dout_en_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              arb_valid;
  logic              arb_grant;
  logic              arb_update;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              ack_next;

  sram_rr_arb u_arb (
    .clk_i     (clk_i),
    .reset_b_i (reset_b_i),
    .req_i     ({p1_req_i, p0_req_i}),
    .update_i  (arb_update),
    .valid_o   (arb_valid),
    .grant_o   (arb_grant)
  );

  assign sel_we    = (arb_grant == PORT_P1) ? p1_we_i    : p0_we_i;
  assign sel_addr  = (arb_grant == PORT_P1) ? p1_addr_i  : p0_addr_i;
  assign sel_wdata = (arb_grant == PORT_P1) ? p1_wdata_i : p0_wdata_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    adr_d      = adr_q;
    dout_d     = dout_q;
    arb_update = 1'b0;
    rdata0_d   = '0;
    rdata1_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          gnt_d      = arb_grant;
          adr_d      = sel_addr;
          if (sel_we) begin
            dout_d  = sel_wdata;
            state_d = ST_WR_SETUP;
          end else begin
            cnt_d   = RD_LOAD;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_DONE;
          if (gnt_q == PORT_P1) rdata1_d = ram_din_i;
          else                  rdata0_d = ram_din_i;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      ST_WR_SETUP: begin
        cnt_d   = WE_LOAD;
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_WR_HOLD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they change on the same
    // edge as the state register and stay glitch-free registered outputs.
    cs_b_d    = (state_d == ST_IDLE) || (state_d == ST_RD_DONE);
    oe_b_d    = (state_d != ST_RD);
    we_b_d    = (state_d != ST_WR_PULSE);
    dout_en_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                (state_d == ST_WR_HOLD);
    ack_next  = (state_d == ST_RD_DONE) || (state_d == ST_WR_HOLD);
    ack0_d    = ack_next && (gnt_d == PORT_P0);
    ack1_d    = ack_next && (gnt_d == PORT_P1);
  end

  always_ff @(posedge clk_i or negedge reset_b_i) begin
    if (!reset_b_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gnt_q     <= PORT_P0;
      cs_b_q    <= 1'b1;
      oe_b_q    <= 1'b1;
      we_b_q    <= 1'b1;
      dout_en_q <= 1'b0;
      adr_q     <= '0;
      dout_q    <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      cs_b_q    <= cs_b_d;
      oe_b_q    <= oe_b_d;
      we_b_q    <= we_b_d;
      dout_en_q <= dout_en_d;
      adr_q     <= adr_d;
      dout_q    <= dout_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign p0_ack_o      = ack0_q;
  assign p1_ack_o      = ack1_q;
  assign p0_rdata_o    = rdata0_q;
  assign p1_rdata_o    = rdata1_q;
  assign ram_cs_b_o    = cs_b_q;
  assign ram_oe_b_o    = oe_b_q;
  assign ram_we_b_o    = we_b_q;
  assign ram_adr_o     = adr_q;
  assign ram_dout_o    = dout_q;
  assign ram_dout_en_o = dout_en_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a default build (RD=2, WE=2) for directed checks
// and an RD=1/WE=1 build for latency plus random dual-port traffic.
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_b;

  logic          a_p0_req, a_p0_we, a_p0_ack, a_p1_req, a_p1_we, a_p1_ack;
  logic [AW-1:0] a_p0_addr, a_p1_addr, a_adr;
  logic [DW-1:0] a_p0_wdata, a_p0_rdata, a_p1_wdata, a_p1_rdata, a_dout, a_din;
  logic          a_cs_b, a_oe_b, a_we_b, a_dout_en;

  logic          b_p0_req, b_p0_we, b_p0_ack, b_p1_req, b_p1_we, b_p1_ack;
  logic [AW-1:0] b_p0_addr, b_p1_addr, b_adr;
  logic [DW-1:0] b_p0_wdata, b_p0_rdata, b_p1_wdata, b_p1_rdata, b_dout, b_din;
  logic          b_cs_b, b_oe_b, b_we_b, b_dout_en;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(2), .WE_CYCLES(2)) u_dut_a (
    .clk_i(clk), .reset_b_i(reset_b),
    .p0_req_i(a_p0_req), .p0_we_i(a_p0_we), .p0_addr_i(a_p0_addr), .p0_wdata_i(a_p0_wdata),
    .p0_ack_o(a_p0_ack), .p0_rdata_o(a_p0_rdata),
    .p1_req_i(a_p1_req), .p1_we_i(a_p1_we), .p1_addr_i(a_p1_addr), .p1_wdata_i(a_p1_wdata),
    .p1_ack_o(a_p1_ack), .p1_rdata_o(a_p1_rdata),
    .ram_cs_b_o(a_cs_b), .ram_oe_b_o(a_oe_b), .ram_we_b_o(a_we_b), .ram_adr_o(a_adr),
    .ram_dout_o(a_dout), .ram_dout_en_o(a_dout_en), .ram_din_i(a_din)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(1), .WE_CYCLES(1)) u_dut_b (
    .clk_i(clk), .reset_b_i(reset_b),
    .p0_req_i(b_p0_req), .p0_we_i(b_p0_we), .p0_addr_i(b_p0_addr), .p0_wdata_i(b_p0_wdata),
    .p0_ack_o(b_p0_ack), .p0_rdata_o(b_p0_rdata),
    .p1_req_i(b_p1_req), .p1_we_i(b_p1_we), .p1_addr_i(b_p1_addr), .p1_wdata_i(b_p1_wdata),
    .p1_ack_o(b_p1_ack), .p1_rdata_o(b_p1_rdata),
    .ram_cs_b_o(b_cs_b), .ram_oe_b_o(b_oe_b), .ram_we_b_o(b_we_b), .ram_adr_o(b_adr),
    .ram_dout_o(b_dout), .ram_dout_en_o(b_dout_en), .ram_din_i(b_din)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit [DW-1:0] a_mem [0:(1<<AW)-1];
  bit [DW-1:0] b_mem [0:(1<<AW)-1];
  bit [DW-1:0] b_ref [0:15];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  // SRAM pad models: commit a write when we_b rises, drive din while cs/oe low.
  bit a_we_prev = 1'b1;
  bit b_we_prev = 1'b1;
  always @(negedge clk) begin
    if (!reset_b) begin
      a_we_prev = 1'b1;
      b_we_prev = 1'b1;
      a_din = '0;
      b_din = '0;
    end else begin
      if (!a_we_prev && a_we_b) begin
        chk("a_dout_en_past_we", 32'(a_dout_en), 1);
        chk("a_cs_past_we", 32'(a_cs_b), 0);
        a_mem[a_adr] = a_dout;
      end
      if (!b_we_prev && b_we_b) begin
        chk("b_dout_en_past_we", 32'(b_dout_en), 1);
        b_mem[b_adr] = b_dout;
      end
      a_we_prev = a_we_b;
      b_we_prev = b_we_b;
      if (a_p0_ack || a_p1_ack) chk("a_one_ack", 32'(a_p0_ack & a_p1_ack), 0);
      if (b_p0_ack || b_p1_ack) chk("b_one_ack", 32'(b_p0_ack & b_p1_ack), 0);
      a_din = (!a_oe_b && !a_cs_b) ? a_mem[a_adr] : 16'hDEAD;
      b_din = (!b_oe_b && !b_cs_b) ? b_mem[b_adr] : 16'hDEAD;
    end
  end

  task automatic a_access(input int port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input bit chk_adr,
                          output int lat, output logic [DW-1:0] rd);
    bit got = 1'b0;
    lat = -1;
    rd  = '0;
    if (port == 0) begin
      a_p0_req = 1'b1; a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wd;
    end else begin
      a_p1_req = 1'b1; a_p1_we = we; a_p1_addr = addr; a_p1_wdata = wd;
    end
    for (int n = 1; n <= 30 && !got; n++) begin
      @(posedge clk); @(negedge clk);
      if (chk_adr && n == 1) begin
        chk("a_adr", 32'(a_adr), 32'(addr));
        chk("a_cs_active", 32'(a_cs_b), 0);
      end
      if (port == 0 ? a_p0_ack : a_p1_ack) begin
        got = 1'b1;
        lat = n + 1;
        rd  = (port == 0) ? a_p0_rdata : a_p1_rdata;
        chk("a_other_ack", 32'(port == 0 ? a_p1_ack : a_p0_ack), 0);
        chk("a_other_rdata", 32'(port == 0 ? a_p1_rdata : a_p0_rdata), 0);
      end
    end
    @(posedge clk); @(negedge clk);
    if (port == 0) a_p0_req = 1'b0;
    else           a_p1_req = 1'b0;
  endtask

  task automatic b_access(input int port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output int lat,
                          output logic [DW-1:0] rd, output logic [DW-1:0] exp_rd);
    bit got = 1'b0;
    lat    = -1;
    rd     = '0;
    exp_rd = '0;
    if (port == 0) begin
      b_p0_req = 1'b1; b_p0_we = we; b_p0_addr = addr; b_p0_wdata = wd;
    end else begin
      b_p1_req = 1'b1; b_p1_we = we; b_p1_addr = addr; b_p1_wdata = wd;
    end
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk); @(negedge clk);
      if (port == 0 ? b_p0_ack : b_p1_ack) begin
        got = 1'b1;
        lat = n + 1;
        rd  = (port == 0) ? b_p0_rdata : b_p1_rdata;
        chk("b_other_ack", 32'(port == 0 ? b_p1_ack : b_p0_ack), 0);
        if (we) b_ref[addr[3:0]] = wd;
        else    exp_rd = b_ref[addr[3:0]];
      end
    end
    @(posedge clk); @(negedge clk);
    if (port == 0) b_p0_req = 1'b0;
    else           b_p1_req = 1'b0;
  endtask

  task automatic b_worker(input int port, input int count);
    int            lat;
    logic [DW-1:0] rd, exp_rd, wd;
    logic [AW-1:0] ad;
    bit            we;
    for (int i = 0; i < count; i++) begin
      we = 1'($urandom_range(0, 1));
      ad = AW'($urandom_range(0, 15));
      wd = DW'($urandom);
      b_access(port, we, ad, wd, lat, rd, exp_rd);
      chk("b_rand_done", 32'(lat > 0), 1);
      chk(we ? "b_rand_wr_rdata" : "b_rand_rd_data", 32'(rd), 32'(exp_rd));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  typedef struct {
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_lat;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat, k, acks, busy_after;
    logic [DW-1:0] rd, exp_rd, rdv;
    bit            got, seen, first_p1;

    vecs[0] = '{0, 1'b1, 18'h00123, 16'hBEEF, 5, 16'h0000};
    vecs[1] = '{0, 1'b0, 18'h00123, 16'h0000, 4, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 18'h3FFFF, 16'h1234, 5, 16'h0000};
    vecs[3] = '{1, 1'b0, 18'h3FFFF, 16'h0000, 4, 16'h1234};
    vecs[4] = '{1, 1'b1, 18'h00000, 16'hA5A5, 5, 16'h0000};
    vecs[5] = '{0, 1'b0, 18'h00000, 16'h0000, 4, 16'hA5A5};
    vecs[6] = '{0, 1'b0, 18'h3FFFF, 16'h0000, 4, 16'h1234};
    vecs[7] = '{1, 1'b0, 18'h00123, 16'h0000, 4, 16'hBEEF};

    reset_b = 1'b0;
    a_p0_req = 0; a_p0_we = 0; a_p0_addr = '0; a_p0_wdata = '0;
    a_p1_req = 0; a_p1_we = 0; a_p1_addr = '0; a_p1_wdata = '0;
    b_p0_req = 0; b_p0_we = 0; b_p0_addr = '0; b_p0_wdata = '0;
    b_p1_req = 0; b_p1_we = 0; b_p1_addr = '0; b_p1_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_cs_b", 32'(a_cs_b), 1);
    chk("rst_oe_b", 32'(a_oe_b), 1);
    chk("rst_we_b", 32'(a_we_b), 1);
    chk("rst_dout_en", 32'(a_dout_en), 0);
    chk("rst_adr", 32'(a_adr), 0);
    chk("rst_dout", 32'(a_dout), 0);
    chk("rst_p0_ack", 32'(a_p0_ack), 0);
    chk("rst_p1_ack", 32'(a_p1_ack), 0);
    chk("rst_p0_rdata", 32'(a_p0_rdata), 0);
    chk("rst_p1_rdata", 32'(a_p1_rdata), 0);
    reset_b = 1'b1;

    // Contention straight after reset: p0 first, then strict alternation.
    a_p0_req = 1; a_p0_we = 0; a_p0_addr = 18'h00010;
    a_p1_req = 1; a_p1_we = 1; a_p1_addr = 18'h00010; a_p1_wdata = 16'h5555;
    k = 0;
    for (int c = 0; c < 80 && k < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (a_p0_ack || a_p1_ack) begin
        chk("a_rr_order", 32'(a_p1_ack), k % 2);
        if (a_p0_ack) chk("a_rr_rdata", 32'(a_p0_rdata), (k == 0) ? 0 : 32'h5555);
        k++;
      end
    end
    chk("a_rr_count", k, 6);
    @(posedge clk); @(negedge clk);
    a_p0_req = 0; a_p1_req = 0;
    @(negedge clk);

    foreach (vecs[i]) begin
      a_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b1, lat, rd);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
    end

    // Back-to-back p1 reads at the address extremes with one idle cycle.
    a_access(1, 1'b0, 18'h3FFFF, 16'h0, 1'b1, lat, rd);
    chk("b2b_first_rdata", 32'(rd), 32'h1234);
    chk("b2b_idle_cs", 32'(a_cs_b), 1);
    a_access(1, 1'b0, 18'h00000, 16'h0, 1'b1, lat, rd);
    chk("b2b_second_lat", lat, 4);
    chk("b2b_second_rdata", 32'(rd), 32'hA5A5);
    @(negedge clk);

    // p0 drops req in the middle of a read.
    a_p0_req = 1; a_p0_we = 0; a_p0_addr = 18'h00123;
    @(posedge clk); @(negedge clk);
    a_p0_req = 0;
    acks = 0; busy_after = 0; seen = 0; rdv = '0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (a_p0_ack) begin
        acks++; rdv = a_p0_rdata; seen = 1;
      end else if (seen && !a_cs_b) begin
        busy_after++;
      end
    end
    chk("drop_ack_count", acks, 1);
    chk("drop_rdata", 32'(rdv), 32'hBEEF);
    chk("drop_no_regrant", busy_after, 0);

    // Reset while the write strobe is low.
    a_p0_req = 1; a_p0_we = 1; a_p0_addr = 18'h00200; a_p0_wdata = 16'h7777;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk); @(negedge clk);
      if (!a_we_b) got = 1;
    end
    chk("rstw_reached_pulse", 32'(got), 1);
    #2 reset_b = 1'b0;
    #1;
    chk("rstw_we_b", 32'(a_we_b), 1);
    chk("rstw_cs_b", 32'(a_cs_b), 1);
    chk("rstw_dout_en", 32'(a_dout_en), 0);
    chk("rstw_ack", 32'(a_p0_ack), 0);
    a_p0_req = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rstw_no_ack", 32'(a_p0_ack), 0);
    end
    reset_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstw_idle_after", 32'(a_cs_b), 1);
    end

    // Round-robin pointer must be back at port 1 after reset: p0 wins again.
    a_p0_req = 1; a_p0_we = 0; a_p0_addr = 18'h00123;
    a_p1_req = 1; a_p1_we = 0; a_p1_addr = 18'h3FFFF;
    k = 0; first_p1 = 1;
    for (int c = 0; c < 20 && k < 1; c++) begin
      @(posedge clk); @(negedge clk);
      if (a_p0_ack || a_p1_ack) begin
        first_p1 = a_p1_ack;
        k++;
      end
    end
    chk("rstw_first_grant_p1", 32'(first_p1), 0);
    a_p0_req = 0;
    k = 0;
    for (int c = 0; c < 20 && k < 1; c++) begin
      @(posedge clk); @(negedge clk);
      if (a_p1_ack) k++;
    end
    chk("rstw_p1_served", k, 1);
    @(posedge clk); @(negedge clk);
    a_p1_req = 0;
    @(negedge clk);

    // RD=1 / WE=1 build.
    b_access(0, 1'b1, 18'd5, 16'h1111, lat, rd, exp_rd);
    chk("b_wr_lat", lat, 4);
    b_access(0, 1'b0, 18'd5, 16'h0, lat, rd, exp_rd);
    chk("b_rd_lat", lat, 3);
    chk("b_rd_data", 32'(rd), 32'h1111);
    b_access(1, 1'b0, 18'd5, 16'h0, lat, rd, exp_rd);
    chk("b_p1_rd_lat", lat, 3);
    chk("b_p1_rd_data", 32'(rd), 32'(exp_rd));

    fork
      b_worker(0, 40);
      b_worker(1, 40);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
